pmod_jstk_spi_ctrl: RTL and testbench

PMOD_JSTK_SPI_CTRL -- requirements
Module: pmod_jstk_spi_ctrl

---
 rtl/jstk_pkg.sv | 33 +++
 rtl/pmod_jstk_spi_ctrl_shift.sv | 61 ++++++
 rtl/pmod_jstk_spi_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pmod_jstk_spi_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI controller: FSM state encoding,
// frame constants and elaboration-time helpers for counter sizing.
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } jstk_state_e;

    // Bytes exchanged per transaction; byte 0 carries the command.
    localparam int NBYTES = 5;

    // Upper six bits of the command byte; the low two bits are the LED controls.
    localparam logic [5:0] CMD_PREFIX = 6'b100000;

    // Bytes 1..4 are dummy bytes that only clock the joystick's data out.
    localparam logic [7:0] FILL_BYTE = 8'h00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of the shared half-period / setup / gap down-counter.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/pmod_jstk_spi_ctrl_shift.sv
// 8-bit SPI byte shifter: parallel load of the outgoing byte, MSB-first
// shift-out on SCLK falling edges, shift-in of MISO on SCLK rising edges,
// and a falling-edge bit counter that flags the end of the byte.
module spi_byte_shift (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       shift_i,
    input  logic       sample_i,
    input  logic       miso_i,
    output logic       mosi_o,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o
);

    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rx_d;
    logic [2:0] bit_cnt_q;
    logic       done_q;

    // Next receive value: MISO enters at the LSB so the first bit ends up as the MSB.
    always_comb begin
        rx_d = {rx_q[6:0], miso_i};
    end

    // Transmit register and bit counter; a load always wins over a shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q      <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (load_i) begin
            tx_q      <= load_data_i;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (shift_i) begin
            tx_q <= {tx_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd7) begin
                done_q <= 1'b1;
            end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // Receive register, clocked only on SCLK rising edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_q <= '0;
        end else if (sample_i) begin
            rx_q <= rx_d;
        end
    end

    assign mosi_o      = tx_q[7];
    assign rx_byte_o   = rx_q;
    assign byte_done_o = done_q;

endmodule

// File: rtl/pmod_jstk_spi_ctrl.sv
// PmodJSTK SPI master: on each accepted SNDREC rising edge sends the LED
// command byte plus four dummy bytes (SPI mode 0, MSB first) and returns the
// five received bytes on DOUT with a one-cycle DVALID pulse.
module pmod_jstk_spi_ctrl
    import jstk_pkg::*;
#(
    parameter int SCLK_HALF = 750,
    parameter int SS_SETUP  = 1500,
    parameter int BYTE_GAP  = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNDREC,
    input  logic [1:0]  DIN,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic        BUSY,
    output logic [39:0] DOUT,
    output logic        DVALID
);

    localparam int CNT_W = cnt_width(max3(SCLK_HALF, SS_SETUP, BYTE_GAP));
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LD   = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(BYTE_GAP - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);

    jstk_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       byte_q;
    logic             sndrec_q;
    logic             ss_q;
    logic             sclk_q;
    logic             busy_q;
    logic             dvalid_q;
    logic [39:0]      dout_q;
    logic [31:0]      acc_q;

    logic             start_edge;
    logic             tick;
    logic             sh_load;
    logic [7:0]       sh_load_data;
    logic             sh_shift;
    logic             sh_sample;
    logic             sh_mosi;
    logic [7:0]       sh_rx;
    logic             sh_done;

    // Edge detect, interval tick and strobes that steer the byte shifter.
    always_comb begin
        start_edge   = SNDREC & ~sndrec_q;
        tick         = (cnt_q == '0);
        cnt_d        = cnt_q - CNT_W'(1);
        sh_load      = ((state_q == ST_IDLE) && start_edge) || ((state_q == ST_GAP) && tick);
        sh_load_data = (state_q == ST_IDLE) ? {CMD_PREFIX, DIN} : FILL_BYTE;
        // Falling edge of SCLK: the next bit goes out on MOSI.
        sh_shift     = (state_q == ST_SHIFT) && tick && sclk_q;
        // Rising edge of SCLK: from SETUP/GAP into a byte, or mid-byte.
        sh_sample    = (tick && ((state_q == ST_SETUP) || (state_q == ST_GAP))) ||
                       ((state_q == ST_SHIFT) && tick && !sclk_q && !sh_done);
    end

    spi_byte_shift u_shift (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .load_i      (sh_load),
        .load_data_i (sh_load_data),
        .shift_i     (sh_shift),
        .sample_i    (sh_sample),
        .miso_i      (MISO),
        .mosi_o      (sh_mosi),
        .rx_byte_o   (sh_rx),
        .byte_done_o (sh_done)
    );

    // Transaction FSM with its timing counter and registered SPI/handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            sndrec_q <= 1'b1;
            ss_q     <= 1'b1;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            acc_q    <= '0;
        end else begin
            sndrec_q <= SNDREC;
            dvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_SETUP;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        byte_q  <= '0;
                        cnt_q   <= SETUP_LD;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                        sclk_q  <= 1'b1;
                        cnt_q   <= HALF_LD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_SHIFT: begin
                    if (!tick) begin
                        cnt_q <= cnt_d;
                    end else if (sclk_q) begin
                        sclk_q <= 1'b0;
                        cnt_q  <= HALF_LD;
                    end else if (!sh_done) begin
                        sclk_q <= 1'b1;
                        cnt_q  <= HALF_LD;
                    end else if (byte_q == LAST_BYTE) begin
                        state_q  <= ST_DONE;
                        ss_q     <= 1'b1;
                        dvalid_q <= 1'b1;
                        dout_q   <= {acc_q, sh_rx};
                    end else begin
                        state_q <= ST_GAP;
                        acc_q   <= {acc_q[23:0], sh_rx};
                        byte_q  <= byte_q + 3'd1;
                        cnt_q   <= GAP_LD;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state_q <= ST_SHIFT;
                        sclk_q  <= 1'b1;
                        cnt_q   <= HALF_LD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SS     = ss_q;
    assign SCLK   = sclk_q;
    assign MOSI   = sh_mosi;
    assign BUSY   = busy_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;

endmodule

// File: tb/tb_pmod_jstk_spi_ctrl.sv
// Scoreboard bench for pmod_jstk_spi_ctrl with a joystick slave model and a
// continuously running SPI protocol checker.
module tb_pmod_jstk_spi_ctrl;

    localparam int SH  = 2;
    localparam int SU  = 4;
    localparam int BG  = 3;
    localparam int LAT = SU + 5 * 16 * SH + 4 * BG + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SNDREC = 1'b0;
    logic [1:0]  DIN = 2'b00;
    logic        MISO;
    logic        SS, SCLK, MOSI, BUSY, DVALID;
    logic [39:0] DOUT;

    always #5 CLK = ~CLK;

    pmod_jstk_spi_ctrl #(
        .SCLK_HALF (SH),
        .SS_SETUP  (SU),
        .BYTE_GAP  (BG)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SNDREC (SNDREC),
        .DIN    (DIN),
        .MISO   (MISO),
        .SS     (SS),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .BUSY   (BUSY),
        .DOUT   (DOUT),
        .DVALID (DVALID)
    );

    typedef struct packed {
        logic [39:0] dout;
        logic [39:0] mosi;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] slave_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Joystick slave: presents its 40-bit reply MSB first, next bit after each
    // SCLK fall, and records MOSI on each SCLK rise.
    logic [39:0] cur_word = '0;
    logic [39:0] mosi_sh = '0;
    int          bidx = 0;
    int          rise_cnt = 0;
    logic        ss_p = 1'b1;
    logic        sclk_p = 1'b0;

    assign MISO = (bidx < 40) ? cur_word[39 - bidx] : 1'b0;

    always @(SS or SCLK) begin
        if (armed) begin
            if (ss_p && !SS) begin
                if (slave_q.size() > 0) begin
                    cur_word = slave_q.pop_front();
                end else begin
                    cur_word = '0;
                    chk("unexpected_ss_fall", 1, 0);
                end
                bidx = 0;
                rise_cnt = 0;
                mosi_sh = '0;
            end else if (sclk_p && !SCLK && !SS) begin
                bidx++;
            end
            if (!sclk_p && SCLK) begin
                mosi_sh = {mosi_sh[38:0], MOSI};
                rise_cnt++;
            end
        end
        ss_p = SS;
        sclk_p = SCLK;
    end

    // Monitor (scoreboard pop on DVALID) and protocol checker, sampled mid-cycle.
    logic busy_p = 0, dv_p = 0, ss_pn = 1, sclk_pn = 0, mosi_pn = 0;
    int   busy_start = 0, ss_fall_cyc = 0, ss_hi_run = 0, last_gap = -1;
    bit   first_rise = 1, seen_txn = 0;

    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (!armed || !RST) begin
            busy_p = 0; dv_p = 0; ss_pn = 1; sclk_pn = 0; first_rise = 1;
            ss_hi_run++;
        end else begin
            chk("sclk_low_when_ss_high", SS & SCLK, 0);
            if (SCLK && sclk_pn) chk("mosi_stable_sclk_high", MOSI, mosi_pn);
            if (!SS && ss_pn) begin
                ss_fall_cyc = cyc;
                first_rise = 0;
                if (seen_txn) begin
                    chk("ss_high_between_txn", ss_hi_run >= 1, 1);
                    last_gap = ss_hi_run;
                end
                seen_txn = 1;
            end
            if (SS) ss_hi_run++; else ss_hi_run = 0;
            if (SCLK && !sclk_pn && !first_rise) begin
                chk("ss_fall_to_first_sclk", cyc - ss_fall_cyc, SU);
                first_rise = 1;
            end
            if (BUSY && !busy_p) busy_start = cyc;
            if (DVALID) begin
                dv_cnt++;
                chk("dvalid_one_cycle", dv_p, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_dvalid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", DOUT, e.dout);
                    chk("mosi_bytes", mosi_sh, e.mosi);
                    chk("sclk_rises", rise_cnt, 40);
                    chk("latency", cyc - busy_start + 1, LAT);
                end
            end
            busy_p = BUSY; dv_p = DVALID; ss_pn = SS; sclk_pn = SCLK; mosi_pn = MOSI;
        end
    end

    // Issue one start edge; the reply and the expected response are queued first.
    task automatic start_txn(input logic [1:0] d, input logic [39:0] w);
        slave_q.push_back(w);
        exp_q.push_back('{dout: w, mosi: {6'b100000, d, 32'h0}});
        DIN = d;
        SNDREC = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        SNDREC = 1'b0;
        DIN = ~d;
    endtask

    task automatic wait_done(input string name);
        int dv0;
        bit got;
        dv0 = dv_cnt;
        got = 0;
        for (int i = 0; i < LAT + 100 && !got; i++) begin
            @(negedge CLK);
            #1;
            if (dv_cnt > dv0) got = 1;
        end
        chk(name, got, 1);
    endtask

    function automatic logic [39:0] rand_word();
        return {8'($urandom), $urandom};
    endfunction

    initial begin
        int  dv0;
        bit  busy_seen;

        #2 RST = 1'b0;
        #1;
        chk("rst_ss", SS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_dvalid", DVALID, 0);
        chk("rst_dout", DOUT, 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        armed = 1;
        repeat (2) @(posedge CLK);
        #1;

        // Reference transaction.
        start_txn(2'b10, 40'hA5013C0206);
        wait_done("txn_basic_done");

        // Second edge while busy is ignored.
        repeat (3) @(posedge CLK);
        #1;
        start_txn(2'($urandom), rand_word());
        repeat (20) @(posedge CLK);
        #1 SNDREC = 1'b1;
        repeat (2) @(posedge CLK);
        #1 SNDREC = 1'b0;
        wait_done("txn_busy_pulse_done");
        repeat (LAT + 20) @(posedge CLK);
        #1;
        chk("one_dvalid_per_accepted_edge", dv_cnt, 2);

        // Back-to-back: next edge in the first IDLE cycle after DONE.
        start_txn(2'($urandom), rand_word());
        wait_done("b2b_first_done");
        @(posedge CLK);
        #1;
        start_txn(2'($urandom), rand_word());
        wait_done("b2b_second_done");
        chk("b2b_ss_high_cycles", last_gap, 2);

        // Reset during byte 2.
        repeat (3) @(posedge CLK);
        #1;
        start_txn(2'($urandom), rand_word());
        for (int i = 0; i < 400 && rise_cnt < 19; i++) @(posedge CLK);
        chk("reached_byte2", rise_cnt >= 19, 1);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        chk("abort_ss", SS, 1);
        chk("abort_sclk", SCLK, 0);
        chk("abort_dvalid", DVALID, 0);
        chk("abort_dout_cleared", DOUT, 0);
        exp_q.delete();
        dv0 = dv_cnt;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        chk("no_dvalid_after_abort", dv_cnt, dv0);
        start_txn(2'($urandom), rand_word());
        wait_done("txn_after_abort_done");

        // SNDREC held high through reset release.
        repeat (3) @(posedge CLK);
        #3 RST = 1'b0;
        #1 SNDREC = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (BUSY) busy_seen = 1;
        end
        chk("no_txn_sndrec_high_at_release", busy_seen, 0);
        @(posedge CLK);
        #1 SNDREC = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        start_txn(2'($urandom), rand_word());
        wait_done("txn_after_sndrec_fall_done");

        // Randomized transactions.
        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(1, 5)) @(posedge CLK);
            #1;
            start_txn(2'($urandom), rand_word());
            wait_done("txn_random_done");
        end

        repeat (20) @(posedge CLK);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("slave_queue_empty", slave_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
